intt_stream_ctrl: RTL and testbench

//  Streaming sequencer wrapped around the combinational intt core. Accepts D
//  N-bit coefficients serially over a valid/ready port and packs them into
//  the core input bus. Waits LAT cycles for the core to settle, then captures
//  the core output and streams the D results back out over valid/ready.
//  One frame is in flight at a time; the core input stays stable while it

---
 rtl/intt_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_intt_stream_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/intt_stream_ctrl.sv
// -----------------------------------------------------------------------------
// intt_stream_ctrl
//
// Streaming sequencer that sits around the combinational intt core. It
// collects one frame of D coefficients from a valid/ready input stream and
// packs them into a registered core input bus. The bus is held stable for LAT
// cycles so the core can settle. The core output is then captured into a
// result buffer and streamed back out, one coefficient per beat. Only one
// frame is in flight at a time.
//
// Parameters
//   N    coefficient width in bits
//   D    coefficients per frame (power of 2, >= 2)
//   LAT  settle cycles allowed for the core before capture (>= 1)
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous reset, active-high
//   in_valid   in   1     in_data holds a coefficient
//   in_ready   out  1     controller can accept a coefficient (LOAD only)
//   in_data    in   N     input coefficient, frame order 0..D-1
//   core_an    out  N*D   registered core input, slot i at [N*(i+1)-1:N*i]
//   core_a     in   N*D   core output, same packing
//   out_valid  out  1     out_data holds a result (UNLOAD only)
//   out_ready  in   1     downstream accepts out_data
//   out_data   out  N     result coefficient, order 0..D-1
//   out_last   out  1     marks the beat carrying index D-1
//   busy       out  1     high while waiting on the core or unloading
//
// Every output is decoded from registered state, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module intt_stream_ctrl #(
  parameter int N   = 9,
  parameter int D   = 8,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  output logic [N*D-1:0] core_an,
  input  logic [N*D-1:0] core_a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_last,
  output logic           busy
);

  localparam int IDX_W  = $clog2(D);
  localparam int WCNT_W = $clog2(LAT + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(D - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_WAIT   = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t              state_q,   state_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [WCNT_W-1:0]   wait_q,    wait_d;
  logic [N*D-1:0]      core_an_q, core_an_d;
  logic [N*D-1:0]      res_q,     res_d;

  // Next-state logic. The same index register walks the input slots during
  // LOAD and the result slots during UNLOAD; it is cleared on each exit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    core_an_d = core_an_q;
    res_d     = res_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          core_an_d[idx_q*N +: N] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            wait_d  = '0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_WAIT: begin
        // The counter tops out at LAT, which its width always holds, and it
        // is cleared again before the next WAIT.
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_LAST) begin
          res_d   = core_a;
          state_d = S_UNLOAD;
        end
      end

      S_UNLOAD: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
        wait_d  = '0;
      end
    endcase
  end

  // State and data registers. Reset also clears the core input bus and the
  // result buffer, so a partially loaded frame leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      wait_q    <= '0;
      core_an_q <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      core_an_q <= core_an_d;
      res_q     <= res_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_UNLOAD);
    busy      = (state_q == S_WAIT) || (state_q == S_UNLOAD);
    out_last  = (state_q == S_UNLOAD) && (idx_q == IDX_LAST);
    out_data  = '0;
    if (state_q == S_UNLOAD) begin
      out_data = res_q[idx_q*N +: N];
    end
  end

  assign core_an = core_an_q;

endmodule

// File: tb/tb_intt_stream_ctrl.sv
module tb_intt_stream_ctrl;

  localparam int N   = 9;
  localparam int D   = 8;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [N*D-1:0] core_an;
  logic [N*D-1:0] core_a;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           out_last;
  logic           busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  intt_stream_ctrl #(.N(N), .D(D), .LAT(LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_an   (core_an),
    .core_a    (core_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Stand-in for the combinational core: a position-dependent, order-reversing
  // map, so swapped or mixed slots show up in the output stream.
  function automatic logic [N*D-1:0] core_fn(input logic [N*D-1:0] a);
    logic [N*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*N +: N] = N'(a[(D-1-i)*N +: N] * 5 + i + 1);
    end
    return r;
  endfunction

  assign core_a = core_fn(core_an);

  task automatic check_eq(input string tag, input logic [N*D-1:0] got,
                          input logic [N*D-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: a frame buffer filled beat by beat, a countdown of
  // remaining settle cycles, and a queue of results still owed downstream.
  logic [N*D-1:0] m_an;
  int             m_ld;
  int             m_wait;
  logic [N-1:0]   m_oq[$];

  int   cyc        = 0;
  int   last_acc   = -1;
  int   prev_first = -1;
  bit   per_chk    = 1'b0;
  logic prev_ov    = 1'b0;
  logic [N-1:0] prev_od = '0;
  bit   prev_stall = 1'b0;

  function automatic bit m_in_ready();
    return (m_wait == 0) && (m_oq.size() == 0);
  endfunction

  task automatic model_edge(input logic v, input logic [N-1:0] d,
                            input logic ordy, input logic r);
    logic [N*D-1:0] res;
    cyc++;
    if (r) begin
      m_an   = '0;
      m_ld   = 0;
      m_wait = 0;
      m_oq.delete();
    end else if (m_in_ready()) begin
      if (v) begin
        if (m_ld == 0) begin
          if (per_chk && prev_first >= 0)
            check_eq("frame_period", cyc - prev_first, 2*D + LAT);
          prev_first = cyc;
        end
        m_an[m_ld*N +: N] = d;
        m_ld++;
        if (m_ld == D) begin
          m_ld     = 0;
          m_wait   = LAT;
          last_acc = cyc;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        res = core_fn(m_an);
        for (int i = 0; i < D; i++) m_oq.push_back(res[i*N +: N]);
      end
    end else if (ordy) begin
      void'(m_oq.pop_front());
    end
  endtask

  task automatic compare();
    bit           e_ir, e_ov, e_last;
    logic [N-1:0] e_od;
    e_ir   = m_in_ready();
    e_ov   = (m_wait == 0) && (m_oq.size() > 0);
    e_od   = e_ov ? m_oq[0] : '0;
    e_last = e_ov && (m_oq.size() == 1);
    check_eq("in_ready",  in_ready,  e_ir);
    check_eq("out_valid", out_valid, e_ov);
    check_eq("out_data",  out_data,  e_od);
    check_eq("out_last",  out_last,  e_last);
    check_eq("busy",      busy,      !e_ir);
    check_eq("core_an",   core_an,   m_an);
    if (prev_stall) check_eq("stall_hold", out_data, prev_od);
    if (out_valid === 1'b1 && prev_ov !== 1'b1 && last_acc >= 0) begin
      check_eq("latency", cyc - last_acc + 1, LAT + 1);
      last_acc = -1;
    end
    prev_ov = out_valid;
    prev_od = out_data;
  endtask

  task automatic step(input logic v, input logic [N-1:0] d,
                      input logic ordy, input logic r);
    in_valid   = v;
    in_data    = d;
    out_ready  = ordy;
    rst        = r;
    prev_stall = (out_valid === 1'b1) && !ordy && !r;
    @(posedge clk);
    model_edge(v, d, ordy, r);
    #1;
    compare();
  endtask

  // vpat: 0 always valid, 1 every 3rd cycle, 2 random
  // rpat: 0 always ready, 1 pattern 1,0,0, 2 random
  // dmode: 0 random, 1 counting 1..D, 2 zeros, 3 ones
  task automatic run(input int ncyc, input int vpat, input int rpat,
                     input int dmode, input int rst_pct);
    logic         v, ordy, r;
    logic [N-1:0] d;
    for (int k = 0; k < ncyc; k++) begin
      case (vpat)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        default: v = 1'($urandom_range(1));
      endcase
      case (rpat)
        0:       ordy = 1'b1;
        1:       ordy = (k % 3 == 0);
        default: ordy = 1'($urandom_range(1));
      endcase
      case (dmode)
        1:       d = N'(m_ld + 1);
        2:       d = '0;
        3:       d = N'(1);
        default: d = N'($urandom);
      endcase
      r = (rst_pct > 0) && ($urandom_range(99) < rst_pct);
      step(v, d, ordy, r);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_an      = '0;
    m_ld      = 0;
    m_wait    = 0;

    // Reset state, with in_valid asserted to show it is not taken.
    step(1'b1, N'(9), 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Counting frame, then all-zero and all-one frames, no stalls.
    run(2*D + LAT, 0, 0, 1, 0);
    run(2*D + LAT, 0, 0, 2, 0);
    run(2*D + LAT, 0, 0, 3, 0);

    // Backpressure on the output side.
    run(60, 0, 1, 0, 0);

    // Sparse input valids.
    run(70, 1, 0, 0, 0);

    // Reset on the 5th input beat, then a fresh frame.
    step(1'b0, '0, 1'b1, 1'b1);
    run(4, 0, 0, 0, 0);
    step(1'b1, N'($urandom), 1'b1, 1'b1);
    run(2*D + LAT, 0, 0, 0, 0);

    // Reset in the middle of a stalled unload, then a fresh frame.
    run(D + LAT + 3, 0, 1, 0, 0);
    step(1'b1, N'($urandom), 1'b0, 1'b1);
    run(2*D + LAT, 0, 0, 0, 0);

    // Back-to-back frames at full throughput.
    step(1'b0, '0, 1'b1, 1'b1);
    per_chk    = 1'b1;
    prev_first = -1;
    run(3*(2*D + LAT) + 1, 0, 0, 0, 0);
    per_chk    = 1'b0;

    // Random traffic with occasional resets.
    run(500, 2, 2, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
